pg_power_policy: RTL and testbench

Power-policy sequencer directly upstream of the power-gating controller. It watches system wake requests and block activity, and decides when the gated domain should be powered. It drives the controller's `power_on_req` / `power_off_req` and consumes its `power_on_ack` / `power_off_ack`. It also runs a watchdog on both handshakes and reports to the system whether the domain is usable.

---
 rtl/pg_power_policy_if.sv | 27 ++
 rtl/pg_power_policy.sv | 116 +++++++++++
 tb/tb_pg_power_policy.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pg_power_policy_if.sv
// Policy <-> system/controller signal bundle for the power-policy sequencer.
// master: the policy block (drives requests and status).
// slave: the environment (system wake/activity plus the gating controller).
interface pg_power_policy_if;
    logic       wake_req;
    logic       block_busy;
    logic       sleep_allow;
    logic       power_on_ack;
    logic       power_off_ack;
    logic       err_clr;
    logic       power_on_req;
    logic       power_off_req;
    logic       domain_ready;
    logic       wake_pending;
    logic       pwr_err;
    logic [1:0] pg_state;

    modport master (
        input  wake_req, block_busy, sleep_allow, power_on_ack, power_off_ack, err_clr,
        output power_on_req, power_off_req, domain_ready, wake_pending, pwr_err, pg_state
    );

    modport slave (
        output wake_req, block_busy, sleep_allow, power_on_ack, power_off_ack, err_clr,
        input  power_on_req, power_off_req, domain_ready, wake_pending, pwr_err, pg_state
    );
endinterface

// File: rtl/pg_power_policy.sv
// Power-policy sequencer: decides when the gated domain is powered, drives the
// gating controller's on/off request handshake, watches both handshakes for
// timeouts and queues wakes that arrive while a power-down is in progress.
// All outputs come straight from flops (next values decoded from next state).
module pg_power_policy #(
    parameter int unsigned IDLE_TIMEOUT = 16,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pg_power_policy_if.master pif
);
    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_REQ_ON  = 2'd1,
        S_ON      = 2'd2,
        S_REQ_OFF = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             on_req_q, on_req_d;
    logic             off_req_q, off_req_d;
    logic             ready_q, ready_d;
    logic             wake_pend_q, wake_pend_d;
    logic             err_q, err_d;
    logic             idle;
    logic             in_req;
    logic             err_set;

    assign idle    = pif.sleep_allow & ~pif.wake_req & ~pif.block_busy;
    assign in_req  = (state_q == S_REQ_ON) || (state_q == S_REQ_OFF);
    // Fires once, on the edge where the wait reaches ACK_TIMEOUT cycles; the
    // counter then runs on past ACK_LAST so a later err_clr sticks.
    assign err_set = in_req && (ack_cnt_q == ACK_LAST);

    // Next-state, counters, queued wake, sticky error and next output values.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = '0;
        ack_cnt_d   = ack_cnt_q;
        wake_pend_d = wake_pend_q;
        err_d       = err_q;

        case (state_q)
            S_OFF: begin
                if (pif.wake_req || wake_pend_q) state_d = S_REQ_ON;
            end
            S_REQ_ON: begin
                if (pif.power_on_ack) state_d = S_ON;
            end
            S_ON: begin
                if (idle) begin
                    if (idle_cnt_q == IDLE_LAST) state_d = S_REQ_OFF;
                    idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
                end
            end
            S_REQ_OFF: begin
                // A power-down is never withdrawn; a wake is queued instead.
                if (pif.wake_req)      wake_pend_d = 1'b1;
                if (pif.power_off_ack) state_d     = S_OFF;
            end
            default: state_d = S_OFF;
        endcase

        if ((state_d != state_q) && ((state_d == S_REQ_ON) || (state_d == S_REQ_OFF)))
            ack_cnt_d = '0;
        else if (in_req && (ack_cnt_q != CNT_MAX))
            ack_cnt_d = ack_cnt_q + 1'b1;

        if (state_d == S_REQ_ON) wake_pend_d = 1'b0;

        if (err_set)          err_d = 1'b1;
        else if (pif.err_clr) err_d = 1'b0;

        on_req_d  = (state_d == S_REQ_ON);
        off_req_d = (state_d == S_REQ_OFF);
        ready_d   = (state_d == S_ON);
    end

    // State, counters and registered outputs; reset drops every request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            idle_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            on_req_q    <= 1'b0;
            off_req_q   <= 1'b0;
            ready_q     <= 1'b0;
            wake_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            on_req_q    <= on_req_d;
            off_req_q   <= off_req_d;
            ready_q     <= ready_d;
            wake_pend_q <= wake_pend_d;
            err_q       <= err_d;
        end
    end

    assign pif.power_on_req  = on_req_q;
    assign pif.power_off_req = off_req_q;
    assign pif.domain_ready  = ready_q;
    assign pif.wake_pending  = wake_pend_q;
    assign pif.pwr_err       = err_q;
    assign pif.pg_state      = state_q;
endmodule

// File: tb/tb_pg_power_policy.sv
// Directed bench for pg_power_policy (IDLE_TIMEOUT=16, ACK_TIMEOUT=64):
// a vector table for single-cycle behaviour, then hand-written sequences for
// idle power-down, counter restart, queued wake, watchdog and async reset.
module tb_pg_power_policy;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pg_power_policy_if bus ();

    pg_power_policy #(.IDLE_TIMEOUT(16), .ACK_TIMEOUT(64), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wake, busy, sleep, on_ack, off_ack, eclr;
        logic [1:0] st;
        logic       on_req, off_req, rdy, wp, err;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int st, input int on, input int off,
                           input int rdy, input int wp, input int err);
        chk({nm, ".state"},   int'(bus.pg_state),      st);
        chk({nm, ".on_req"},  int'(bus.power_on_req),  on);
        chk({nm, ".off_req"}, int'(bus.power_off_req), off);
        chk({nm, ".ready"},   int'(bus.domain_ready),  rdy);
        chk({nm, ".wpend"},   int'(bus.wake_pending),  wp);
        chk({nm, ".err"},     int'(bus.pwr_err),       err);
    endtask

    task automatic set_in(input logic w, input logic b, input logic s,
                          input logic ona, input logic offa, input logic ec);
        bus.wake_req      = w;
        bus.block_busy    = b;
        bus.sleep_allow   = s;
        bus.power_on_ack  = ona;
        bus.power_off_ack = offa;
        bus.err_clr       = ec;
    endtask

    // From ON with idle inputs applied: 15 edges stay ON, the 16th goes REQ_OFF.
    task automatic idle_down(input string nm);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) tick();
        chk({nm, ".still_on"}, int'(bus.pg_state), 2);
        tick();
        chk({nm, ".req_off_state"}, int'(bus.pg_state), 3);
        chk({nm, ".req_off_req"}, int'(bus.power_off_req), 1);
        chk({nm, ".req_off_rdy"}, int'(bus.domain_ready), 0);
    endtask

    initial begin
        int not_on;
        //          wake busy slp onA offA eclr  st on off rdy wp err
        tbl[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[2] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[3] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[5] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[6] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[7] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[8] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b0,1'b1,1'b0,1'b0};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Single-cycle table: power-up, ignored acks, non-idle holds in ON.
        foreach (tbl[i]) begin
            set_in(tbl[i].wake, tbl[i].busy, tbl[i].sleep, tbl[i].on_ack, tbl[i].off_ack, tbl[i].eclr);
            tick();
            chk_all($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].on_req),
                    int'(tbl[i].off_req), int'(tbl[i].rdy), int'(tbl[i].wp), int'(tbl[i].err));
        end

        // sleep_allow low keeps the domain on even when otherwise idle.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        not_on = 0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (bus.pg_state != 2'd2) not_on++;
        end
        chk("no_sleep.cycles_not_on", not_on, 0);

        // Idle count interrupted by a busy pulse restarts from zero.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        chk("restart.pre_busy", int'(bus.pg_state), 2);
        bus.block_busy = 1'b1;
        tick();
        idle_down("restart");

        // REQ_OFF ignores a lingering on-ack; a wake during it is queued.
        tick();
        tick();
        chk_all("reqoff_onack", 3, 0, 1, 0, 0, 0);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("queue_wake", 3, 0, 1, 0, 1, 0);
        bus.wake_req = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk_all("queue_hold", 3, 0, 1, 0, 1, 0);
        bus.power_off_ack = 1'b1;
        tick();
        chk_all("offack_off", 0, 0, 0, 0, 1, 0);
        bus.power_off_ack = 1'b0;
        tick();
        chk_all("queued_reqon", 1, 1, 0, 0, 0, 0);

        // Watchdog on REQ_ON: set exactly 64 edges after entry, set beats clear.
        for (int k = 1; k <= 64; k++) begin
            bus.err_clr = (k == 64);
            tick();
            if (k == 63) chk("wdog.before", int'(bus.pwr_err), 0);
        end
        chk_all("wdog.set_vs_clr", 1, 1, 0, 0, 0, 1);
        bus.err_clr = 1'b0;
        tick();
        chk_all("wdog.sticky", 1, 1, 0, 0, 0, 1);
        bus.err_clr = 1'b1;
        tick();
        chk("wdog.cleared", int'(bus.pwr_err), 0);
        bus.err_clr = 1'b0;
        tick();
        chk_all("wdog.stays_clr", 1, 1, 0, 0, 0, 0);

        // On-ack together with wake: ON, idle count still starts from zero.
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("ack_wake", 2, 0, 0, 1, 0, 0);
        idle_down("after_ack_wake");

        // Off-ack together with wake: OFF with wake queued, then one OFF cycle.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("offack_wake", 0, 0, 0, 0, 1, 0);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("offack_wake_next", 1, 1, 0, 0, 0, 0);
        bus.power_on_ack = 1'b1;
        tick();
        chk("reon", int'(bus.pg_state), 2);
        idle_down("third_down");

        // Watchdog on REQ_OFF, then asynchronous reset mid-handshake.
        bus.power_on_ack = 1'b0;
        bus.wake_req     = 1'b1;
        tick();
        bus.wake_req = 1'b0;
        for (int k = 2; k <= 64; k++) begin
            tick();
            if (k == 63) chk("wdog_off.before", int'(bus.pwr_err), 0);
        end
        chk_all("wdog_off.set", 3, 0, 1, 0, 1, 1);
        rst_n = 1'b0;
        #2;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_reset", 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
